// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the serial subtractor library.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter must reach WIDTH-1 and still carry its increment without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor built from two half-subtractor stages plus an OR gate.
// Zero latency; no flow control.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  always_comb begin
    hs1_d = a ^ b;
    hs1_b = ~a & b;
    d     = hs1_d ^ bin;
    hs2_b = ~hs1_d & bin;
    bout  = hs1_b | hs2_b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: result WIDTH cycles after start, one op per WIDTH+2 cycles.
// start is honoured only in IDLE; requests arriving while busy are dropped, not queued.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = val1;
          b_d     = val2;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        part_d = {cell_d, part_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = cell_bo;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: the shifted-in partial result is the complete difference.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {cell_d, part_q[WIDTH-1:1]};
          borrow_d = cell_bo;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start5;
  logic [7:0] val1_8, val2_8, diff8;
  logic [4:0] val1_5, val2_5, diff5;
  logic       busy8, done8, borrow8;
  logic       busy5, done5, borrow5;

  int chk;
  int err;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .val1(val1_8), .val2(val2_8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .val1(val1_5), .val2(val2_5),
    .busy(busy5), .done(done5), .diff(diff5), .borrow(borrow5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation on the selected instance and reports latency / busy cycles.
  task automatic run_op(input bit w5, input logic [7:0] v1, input logic [7:0] v2,
                        output int lat, output int busy_cnt);
    int guard;
    guard = 0;
    while ((w5 ? busy5 : busy8) && guard < 40) begin
      tick();
      guard++;
    end
    if (w5) begin
      start5 = 1'b1; val1_5 = v1[4:0]; val2_5 = v2[4:0];
    end else begin
      start8 = 1'b1; val1_8 = v1; val2_8 = v2;
    end
    tick();
    start5 = 1'b0;
    start8 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!(w5 ? done5 : done8) && lat < 40) begin
      if (w5 ? busy5 : busy8) busy_cnt++;
      tick();
      lat++;
    end
    if (w5 ? busy5 : busy8) busy_cnt++;
  endtask

  task automatic test_reset();
    chk++;
    if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
      err++;
      $display("FAIL reset8 got busy=%b done=%b diff=%h borrow=%b want all 0",
               busy8, done8, diff8, borrow8);
    end
    chk++;
    if ({busy5, done5, diff5, borrow5} !== 8'h0) begin
      err++;
      $display("FAIL reset5 got busy=%b done=%b diff=%h borrow=%b want all 0",
               busy5, done5, diff5, borrow5);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(1'b0, 8'h5A, 8'h23, lat, bc);
    chk++;
    if (lat !== 8) begin err++; $display("FAIL basic_latency got %0d want 8", lat); end
    chk++;
    if (bc !== 9) begin err++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
    chk++;
    if ({borrow8, diff8} !== 9'h037) begin
      err++; $display("FAIL basic_result got b=%b d=%h want b=0 d=37", borrow8, diff8);
    end
    tick();
    chk++;
    if (done8 !== 1'b0) begin err++; $display("FAIL done_pulse_width got done=%b want 0", done8); end
    chk++;
    if (diff8 !== 8'h37) begin err++; $display("FAIL hold_after_done got %h want 37", diff8); end
  endtask

  task automatic test_wrap();
    int lat, bc;
    run_op(1'b0, 8'h00, 8'h01, lat, bc);
    chk++;
    if ({borrow8, diff8} !== 9'h1FF) begin
      err++; $display("FAIL wrap_00_01 got b=%b d=%h want b=1 d=ff", borrow8, diff8);
    end
    run_op(1'b0, 8'h80, 8'h80, lat, bc);
    chk++;
    if ({borrow8, diff8} !== 9'h000) begin
      err++; $display("FAIL equal_80_80 got b=%b d=%h want b=0 d=00", borrow8, diff8);
    end
  endtask

  task automatic test_start_ignored();
    int n, extra;
    while (busy8) tick();
    start8 = 1'b1; val1_8 = 8'h10; val2_8 = 8'h01;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; val1_8 = 8'hAA; val2_8 = 8'h11;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin tick(); n++; end
    chk++;
    if ({done8, borrow8, diff8} !== 10'h20F) begin
      err++; $display("FAIL start_in_run got done=%b b=%b d=%h want done=1 b=0 d=0f",
                      done8, borrow8, diff8);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) extra++;
    end
    chk++;
    if (extra !== 0) begin err++; $display("FAIL no_second_done got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_operand_change();
    int n, hold_bad;
    while (busy8) tick();
    start8 = 1'b1; val1_8 = 8'hC3; val2_8 = 8'h5C;
    tick();
    start8 = 1'b0;
    n = 0;
    hold_bad = 0;
    while (!done8 && n < 20) begin
      if (diff8 !== 8'h0F) hold_bad++;
      val1_8 = 8'($urandom);
      val2_8 = 8'($urandom);
      tick();
      n++;
    end
    chk++;
    if (hold_bad !== 0) begin err++; $display("FAIL diff_hold_in_run got %0d bad cycles want 0", hold_bad); end
    chk++;
    if ({done8, borrow8, diff8} !== 10'h267) begin
      err++; $display("FAIL operand_change got done=%b b=%b d=%h want done=1 b=0 d=67",
                      done8, borrow8, diff8);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    while (busy8) tick();
    start8 = 1'b1; val1_8 = 8'h44; val2_8 = 8'h11;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk++;
    if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
      err++; $display("FAIL async_reset got busy=%b done=%b diff=%h borrow=%b want all 0",
                      busy8, done8, diff8, borrow8);
    end
    tick();
    #2 rst = 1'b0;
    run_op(1'b0, 8'hFF, 8'h0F, lat, bc);
    chk++;
    if ({borrow8, diff8} !== 9'h0F0) begin
      err++; $display("FAIL after_reset got b=%b d=%h want b=0 d=f0", borrow8, diff8);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    while (busy8) tick();
    start8 = 1'b1; val1_8 = 8'h33; val2_8 = 8'h44;
    tick();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done8) dones.push_back(c);
    end
    start8 = 1'b0;
    chk++;
    if (dones.size() !== 3) begin
      err++; $display("FAIL b2b_count got %0d done pulses want 3", dones.size());
    end else begin
      chk++;
      if (dones[0] !== 8 || dones[1] !== 18 || dones[2] !== 28) begin
        err++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 8,18,28", dones[0], dones[1], dones[2]);
      end
    end
    chk++;
    if ({borrow8, diff8} !== 9'h1EF) begin
      err++; $display("FAIL b2b_result got b=%b d=%h want b=1 d=ef", borrow8, diff8);
    end
  endtask

  task automatic test_width5();
    int lat, bc;
    run_op(1'b1, 8'h03, 8'h07, lat, bc);
    chk++;
    if (lat !== 5 || bc !== 6) begin
      err++; $display("FAIL w5_timing got lat=%0d busy=%0d want lat=5 busy=6", lat, bc);
    end
    chk++;
    if ({borrow5, diff5} !== 6'h3C) begin
      err++; $display("FAIL w5_03_07 got b=%b d=%h want b=1 d=1c", borrow5, diff5);
    end
    run_op(1'b1, 8'h1F, 8'h1F, lat, bc);
    chk++;
    if ({borrow5, diff5} !== 6'h00) begin
      err++; $display("FAIL w5_1f_1f got b=%b d=%h want b=0 d=00", borrow5, diff5);
    end
    run_op(1'b1, 8'h00, 8'h1F, lat, bc);
    chk++;
    if ({borrow5, diff5} !== 6'h21) begin
      err++; $display("FAIL w5_00_1f got b=%b d=%h want b=1 d=01", borrow5, diff5);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] v1, v2, e8;
    logic [4:0] e5;
    for (int i = 0; i < 12; i++) begin
      v1 = 8'($urandom_range(0, 255));
      v2 = 8'($urandom_range(0, 255));
      e8 = v1 - v2;
      run_op(1'b0, v1, v2, lat, bc);
      chk++;
      if ({borrow8, diff8} !== {(v1 < v2), e8}) begin
        err++; $display("FAIL rand8 %h-%h got b=%b d=%h want b=%b d=%h",
                        v1, v2, borrow8, diff8, (v1 < v2), e8);
      end
      e5 = v1[4:0] - v2[4:0];
      run_op(1'b1, v1, v2, lat, bc);
      chk++;
      if ({borrow5, diff5} !== {(v1[4:0] < v2[4:0]), e5}) begin
        err++; $display("FAIL rand5 %h-%h got b=%b d=%h want b=%b d=%h",
                        v1[4:0], v2[4:0], borrow5, diff5, (v1[4:0] < v2[4:0]), e5);
      end
    end
  endtask

  initial begin
    chk = 0;
    err = 0;
    rst = 1'b1;
    start8 = 1'b0; val1_8 = '0; val2_8 = '0;
    start5 = 1'b0; val1_5 = '0; val2_5 = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_basic();
    test_wrap();
    test_start_ignored();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    test_width5();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
